// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory arbiter.
//   dbg_state_e    : debug readout FSM encoding
//   owner_e        : owner of the previous cycle's RAM access
//   STARVE_MAX_DEF : default for the CPU-won cycle limit while a debug read waits
//   STARVE_W       : width of the starvation counter
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RD   = 2'd2,
    ST_CAP  = 2'd3
  } dbg_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEF = 15;
  localparam int STARVE_W       = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port synchronous data RAM between the CPU MEM stage and
// a debug readout port. The CPU owns the RAM by default; a pending debug read
// takes one slot when the CPU is idle or after STARVE_MAX CPU-won cycles.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cpu_req/we/addr/wdata              MEM-stage access
//   cpu_rdata, cpu_stall               load data (cycle after grant), freeze
//   memread_en, out_addr               debug readout request (level) and address
//   dbg_data, dbg_valid                captured debug word and its update pulse
//   ram_en/we/addr/wdata, ram_rdata    external single-port RAM
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no debug read outstanding
// PEND    | debug address latched, waiting for a RAM slot
// RD      | debug owns the RAM this cycle, CPU stalled if requesting
// CAP     | RAM data for debug read arrives, captured at end of cycle
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              memread_en,
  input  logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  dbg_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d, starve_inc;
  logic [ADDR_W-1:0]   dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0]   dbg_data_q;
  logic                dbg_valid_q;
  owner_e              owner_q, owner_d;
  logic [DATA_W-1:0]   rdata_hold_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating increment; the counter never wraps back to zero.
  assign starve_inc = (starve_cnt_q == '1) ? starve_cnt_q : starve_cnt_q + STARVE_W'(1);

  // Next-state logic. The starvation test uses the count including the
  // current CPU-won cycle, so exactly STARVE_MAX CPU-won PEND cycles come
  // before the debug slot.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    dbg_addr_d   = dbg_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (memread_en) begin
          state_d      = ST_PEND;
          dbg_addr_d   = out_addr;
          starve_cnt_d = '0;
        end
      end
      ST_PEND: begin
        if (!memread_en) begin
          state_d      = ST_IDLE;
          starve_cnt_d = '0;
        end else if (!cpu_req) begin
          state_d = ST_RD;
        end else begin
          starve_cnt_d = starve_inc;
          if (starve_inc >= STARVE_LIM) begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d      = ST_CAP;
        starve_cnt_d = '0;
      end
      ST_CAP: begin
        starve_cnt_d = '0;
        if (memread_en) begin
          state_d    = ST_PEND;
          dbg_addr_d = out_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. RAM enables are gated by rst_n so nothing is issued while
  // reset is held, whatever the CPU is requesting.
  always_comb begin
    ram_en    = cpu_req;
    ram_we    = cpu_we & cpu_req;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    owner_d   = (cpu_req && !cpu_we) ? OWN_CPU : OWN_NONE;
    if (state_q == ST_RD) begin
      ram_en    = 1'b1;
      ram_we    = 1'b0;
      ram_addr  = dbg_addr_q;
      cpu_stall = cpu_req;
      owner_d   = OWN_DBG;
    end
    if (!rst_n) begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      cpu_stall = 1'b0;
      owner_d   = OWN_NONE;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      dbg_addr_q   <= '0;
      dbg_data_q   <= '0;
      dbg_valid_q  <= 1'b0;
      owner_q      <= OWN_NONE;
      rdata_hold_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dbg_addr_q   <= dbg_addr_d;
      owner_q      <= owner_d;
      // ram_rdata is only valid during CAP; capture and flag together so
      // dbg_valid always marks the cycle dbg_data first shows the new word.
      dbg_valid_q  <= (state_q == ST_CAP);
      if (state_q == ST_CAP) begin
        dbg_data_q <= ram_rdata;
      end
      if (owner_q == OWN_CPU) begin
        rdata_hold_q <= ram_rdata;
      end
    end
  end

  // Load data passes straight through after a CPU read, otherwise the last
  // CPU word is held so debug reads never disturb it.
  assign cpu_rdata = (owner_q == OWN_CPU) ? ram_rdata : rdata_hold_q;
  assign dbg_data  = dbg_data_q;
  assign dbg_valid = dbg_valid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        memread_en;
  logic [7:0]  out_addr;
  logic [31:0] dbg_data;
  logic        dbg_valid;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  logic [31:0] exp_w [0:3];

  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .memread_en (memread_en),
    .out_addr   (out_addr),
    .dbg_data   (dbg_data),
    .dbg_valid  (dbg_valid),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int served, stalls, k_iss, k_val;
    logic got;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0BAD_F00D;
    mem[1] = 32'h1234_0001;
    mem[2] = 32'hCAFE_0002;
    mem[3] = 32'h5555_AAAA;
    mem[4] = 32'hDEAD_BEEF;
    mem[5] = 32'h0000_0505;
    exp_w[0] = 32'h0BAD_F00D;
    exp_w[1] = 32'h1234_0001;
    exp_w[2] = 32'hCAFE_0002;
    exp_w[3] = 32'h5555_AAAA;
    ram_rdata = 32'h0;

    // Reset with CPU requesting: RAM must stay disabled
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33;
    cpu_wdata = 32'h0; memread_en = 1'b1; out_addr = 8'h07;
    #2;
    chk("rst_ram_en",    32'(ram_en),    32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_dbg_valid", 32'(dbg_valid), 32'd0);
    chk("rst_dbg_data",  dbg_data,       32'd0);
    chk("rst_cpu_rdata", cpu_rdata,      32'd0);
    step(); step();
    chk("rst_ram_en_edges", 32'(ram_en), 32'd0);
    rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; memread_en = 1'b0;
    settle();
    chk("idle_dbg_valid", 32'(dbg_valid), 32'd0);

    // Debug read of 0x04 with idle CPU
    step(); memread_en = 1'b1; out_addr = 8'h04; settle();
    chk("A_idle_ram_en", 32'(ram_en), 32'd0);
    step(); settle();
    chk("A_pend_ram_en", 32'(ram_en), 32'd0);
    step(); settle();
    chk("A_rd_ram_en",    32'(ram_en),    32'd1);
    chk("A_rd_ram_we",    32'(ram_we),    32'd0);
    chk("A_rd_ram_addr",  32'(ram_addr),  32'h04);
    chk("A_rd_cpu_stall", 32'(cpu_stall), 32'd0);
    step(); memread_en = 1'b0; settle();
    chk("A_cap_valid", 32'(dbg_valid), 32'd0);
    step(); settle();
    chk("A_valid", 32'(dbg_valid), 32'd1);
    chk("A_data",  dbg_data,       32'hDEAD_BEEF);
    step(); settle();
    chk("A_valid_pulse", 32'(dbg_valid), 32'd0);
    chk("A_after_ram_en", 32'(ram_en),   32'd0);

    // CPU store then load of 0x10, then debug read of 0x10
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'h1234_5678; settle();
    chk("B_st_ram_en",    32'(ram_en),    32'd1);
    chk("B_st_ram_we",    32'(ram_we),    32'd1);
    chk("B_st_ram_addr",  32'(ram_addr),  32'h10);
    chk("B_st_ram_wdata", ram_wdata,      32'h1234_5678);
    chk("B_st_stall",     32'(cpu_stall), 32'd0);
    step(); cpu_we = 1'b0; cpu_wdata = 32'h0; settle();
    chk("B_ld_ram_we", 32'(ram_we), 32'd0);
    step(); cpu_req = 1'b0; settle();
    chk("B_ld_rdata", cpu_rdata, 32'h1234_5678);
    step(); cpu_addr = 8'h55; settle();
    chk("B_ld_hold", cpu_rdata, 32'h1234_5678);
    step(); memread_en = 1'b1; out_addr = 8'h10; settle();
    step(); out_addr = 8'h99; settle();
    step(); memread_en = 1'b0; settle();
    chk("B_rd_ram_addr", 32'(ram_addr), 32'h10);
    step(); settle();
    chk("B_cap_valid", 32'(dbg_valid), 32'd0);
    chk("B_cap_rdata", cpu_rdata,      32'h1234_5678);
    step(); settle();
    chk("B_valid", 32'(dbg_valid), 32'd1);
    chk("B_data",  dbg_data,       32'h1234_5678);

    // Debug request cancelled while pending
    step(); cpu_req = 1'b1; cpu_addr = 8'h04; memread_en = 1'b1; out_addr = 8'h03; settle();
    step(); memread_en = 1'b0; cpu_req = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("C_ram_en",    32'(ram_en),    32'd0);
      chk("C_dbg_valid", 32'(dbg_valid), 32'd0);
    end

    // CPU hogging: 15 served cycles, one stall, then CPU resumes
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h04; memread_en = 1'b1; out_addr = 8'h05; settle();
    chk("D_idle_stall", 32'(cpu_stall), 32'd0);
    served = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(); settle();
      if (cpu_stall) got = 1'b1;
      else served++;
    end
    chk("D_stall_seen",  32'(got),      32'd1);
    chk("D_served",      served,        32'd15);
    chk("D_rd_ram_addr", 32'(ram_addr), 32'h05);
    chk("D_rd_ram_we",   32'(ram_we),   32'd0);
    memread_en = 1'b0;
    step(); settle();
    chk("D_cap_stall",    32'(cpu_stall), 32'd0);
    chk("D_cap_ram_addr", 32'(ram_addr),  32'h04);
    chk("D_cap_ram_en",   32'(ram_en),    32'd1);
    step(); settle();
    chk("D_valid", 32'(dbg_valid), 32'd1);
    chk("D_data",  dbg_data,       32'h0000_0505);

    // Reset asserted mid-RD
    step(); cpu_req = 1'b0; memread_en = 1'b1; out_addr = 8'h02; settle();
    step(); settle();
    step(); settle();
    chk("E_rd_ram_en",   32'(ram_en),   32'd1);
    chk("E_rd_ram_addr", 32'(ram_addr), 32'h02);
    #1 rst_n = 1'b0; cpu_req = 1'b1; memread_en = 1'b0;
    #1;
    chk("E_rst_ram_en",    32'(ram_en),    32'd0);
    chk("E_rst_stall",     32'(cpu_stall), 32'd0);
    chk("E_rst_dbg_data",  dbg_data,       32'd0);
    chk("E_rst_dbg_valid", 32'(dbg_valid), 32'd0);
    chk("E_rst_cpu_rdata", cpu_rdata,      32'd0);
    step(); rst_n = 1'b1; cpu_req = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      chk("E_post_valid", 32'(dbg_valid), 32'd0);
      step(); settle();
    end

    // Back-to-back reads of 0x00..0x03 with a busy CPU
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20; memread_en = 1'b1; out_addr = 8'h00; settle();
    k_iss = 0; k_val = 0; stalls = 0;
    for (int i = 0; i < 200 && k_val < 4; i++) begin
      step(); settle();
      if (cpu_stall) begin
        stalls++;
        chk("F_rd_addr", 32'(ram_addr), k_iss);
        k_iss++;
        out_addr = 8'(k_iss);
      end
      if (dbg_valid) begin
        chk("F_data", dbg_data, exp_w[k_val]);
        chk("F_stall_per_pulse", 32'(stalls <= 1), 32'd1);
        stalls = 0;
        k_val++;
      end
    end
    chk("F_pulses", k_val, 32'd4);
    memread_en = 1'b0; cpu_req = 1'b0;
    step(); settle();
    step(); settle();
    chk("F_end_valid", 32'(dbg_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 15, max consecutive CPU-won cycles while a debug read is pending.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cpu_req  input  1  MEM-stage access request.
REQ-007 SHALL have port cpu_we  input  1  MEM-stage write enable, qualified by cpu_req.
REQ-008 SHALL have port cpu_addr  input  ADDR_W  MEM-stage word address.
REQ-009 SHALL have port cpu_wdata  input  DATA_W  MEM-stage store data.
REQ-010 SHALL have port cpu_rdata  output  DATA_W  load data, one cycle after the granted read.
REQ-011 SHALL have port cpu_stall  output  1  pipeline freeze; CPU request not served this cycle.
REQ-012 SHALL have port memread_en  input  1  debug readout enable, level.
REQ-013 SHALL have port out_addr  input  ADDR_W  debug readout address.
REQ-014 SHALL have port dbg_data  output  DATA_W  last captured debug word, registered.
REQ-015 SHALL have port dbg_valid  output  1  one-cycle pulse when dbg_data updates.
REQ-016 SHALL have ports ram_en, ram_we (1 each), ram_addr (ADDR_W), ram_wdata (DATA_W)  output  single-port synchronous RAM controls.
REQ-017 SHALL have port ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0.

Function
REQ-018 Debug FSM SHALL have states IDLE, PEND, RD, CAP.
REQ-019 IDLE: memread_en=1 -> PEND, latching out_addr into dbg_addr_q.
REQ-020 PEND: memread_en=0 -> IDLE (cancel); else cpu_req=0 -> RD; else starve_cnt==STARVE_MAX -> RD; else stay and increment starve_cnt.
REQ-021 RD: RAM driven by debug (ram_en=1, ram_we=0, ram_addr=dbg_addr_q); cpu_stall=cpu_req; starve_cnt cleared; always -> CAP.
REQ-022 CAP: dbg_data<=ram_rdata, dbg_valid=1 for this cycle; then -> PEND with out_addr re-latched if memread_en=1, else IDLE.
REQ-023 In every state except RD, RAM SHALL be driven combinationally by the CPU: ram_en=cpu_req, ram_we=cpu_we&cpu_req, ram_addr=cpu_addr, ram_wdata=cpu_wdata; cpu_stall=0.
REQ-024 cpu_rdata SHALL equal ram_rdata combinationally when the previous cycle's RAM access was a CPU read; otherwise it SHALL hold its last CPU value, via a registered last-owner flag.
REQ-025 A CPU access and a debug access SHALL never be issued to the RAM in the same cycle.
REQ-026 A stalled CPU request SHALL be served the next cycle (CAP never stalls), giving maximum CPU stall 1 cycle per debug read.
REQ-027 starve_cnt SHALL be 4 bits wide, sized for STARVE_MAX, and SHALL saturate, never wrap.
REQ-028 memread_en falling while in RD or CAP SHALL let the in-flight read complete and capture, then go to IDLE.
REQ-029 out_addr changes SHALL only take effect at the next latch point (IDLE->PEND or CAP->PEND).

Reset
REQ-030 rst_n=0 SHALL asynchronously force: FSM=IDLE, starve_cnt=0, dbg_addr_q=0, dbg_data=0, dbg_valid=0, last-owner=none, cpu_rdata hold register=0.
REQ-031 During reset, outputs SHALL be cpu_stall=0 and ram_en=0, with ram_en=0 regardless of cpu_req.
REQ-032 Reset asserted mid-RD SHALL discard the read; no dbg_valid SHALL follow reset release.

Structure
REQ-033 FSM state encoding and STARVE_MAX default SHALL live in shared package cpu_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the RAM stays outside, instantiated by top.

Verification
REQ-035 memread_en=1, out_addr=0x04, RAM[4]=0xDEADBEEF, cpu_req=0 -> ram_en with addr 0x04 two cycles after enable; dbg_data=0xDEADBEEF and dbg_valid pulse one cycle later.
REQ-036 cpu_req=1 continuously with a debug read pending -> exactly 15 CPU-served cycles, then one cycle with cpu_stall=1 and debug access, then CPU resumes with no stall.
REQ-037 CPU store addr 0x10 data 0x12345678, then debug read of 0x10 -> dbg_data=0x12345678; CPU load of 0x10 -> cpu_rdata=0x12345678 one cycle after grant.
REQ-038 memread_en dropped while in PEND -> return to IDLE, no ram_en from debug, no dbg_valid.
REQ-039 rst_n pulsed low during RD -> all outputs at reset values immediately; no dbg_valid after release.
REQ-040 memread_en held high, out_addr stepping 0x00..0x03 -> successive dbg_valid pulses with matching RAM words; CPU stall count <= 1 per pulse.
